// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_pkg
//  Description : Shared types and default constants for the toggle-handshake
//                CDC link (transmitter and receiver sides).
//  Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

    // Transmitter handshake state
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } cdc_state_t;

    // Default configuration
    localparam int c_data_width_dflt     = 8;
    localparam int c_num_stages_dflt     = 2;
    localparam int c_timeout_cycles_dflt = 255;

    // Legal synchronizer depth
    localparam int c_num_stages_min = 2;
    localparam int c_num_stages_max = 4;

endpackage : cdc_pkg
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
//  Module      : bit_sync
//  Description : Single-bit multi-flop synchronizer, asynchronous active-low
//                reset to 0. Used for the ACK toggle here and for the REQ
//                toggle on the receiving side.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_sync
    import cdc_pkg::*;
#(
    parameter int NUM_STAGES = c_num_stages_dflt
) (
    input  logic CLK,
    input  logic RST,
    input  logic SYNC_IN,
    output logic SYNC_OUT
);

    logic [NUM_STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_STAGES-2:0], SYNC_IN};
        end
    end

    assign SYNC_OUT = r_sync[NUM_STAGES-1];

endmodule : bit_sync
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_handshake_tx
//  Description : Source side of the two-phase toggle handshake CDC link.
//                Accepts a word on valid/ready, holds it on TX_DATA, flips
//                TX_REQ_TGL, and waits until the synchronized ACK_TGL matches
//                before accepting the next word.
//                Optional feature macro: CDC_TX_TIMEOUT_EN (sticky ERR after
//                TIMEOUT_CYCLES cycles without acknowledge).
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = c_data_width_dflt,
    parameter int NUM_STAGES     = c_num_stages_dflt,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles_dflt
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  IN_READY,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_REQ_TGL,
    input  logic                  ACK_TGL,
    output logic                  DONE,
    output logic                  ERR
);

    // Elaboration-time parameter sanity
    if (NUM_STAGES < c_num_stages_min || NUM_STAGES > c_num_stages_max) begin : g_bad_stages
        $error("cdc_handshake_tx: NUM_STAGES out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cdc_handshake_tx: TIMEOUT_CYCLES must be at least 1");
    end

    cdc_state_t              r_state;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_req_tgl;
    logic                    r_done;
    logic                    w_ack_sync;
    logic                    w_in_ready;
    logic                    w_accept;

    bit_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .CLK      (CLK),
        .RST      (RST),
        .SYNC_IN  (ACK_TGL),
        .SYNC_OUT (w_ack_sync)
    );

    // Ready is held off during the DONE cycle so DONE and IN_READY never overlap
    assign w_in_ready = RST && (r_state == IDLE) && !r_done;
    assign w_accept   = IN_VALID && w_in_ready;

    // Handshake FSM: launch on accept, complete when the ack level catches up
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_tx_data <= '0;
            r_req_tgl <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tx_data <= IN_DATA;
                        r_req_tgl <= ~r_req_tgl;
                        r_state   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (w_ack_sync == r_req_tgl) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_max  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Saturating wait counter; ERR is sticky because the request cannot be withdrawn
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == WAIT_ACK) begin
                if (r_cnt != c_timeout_max) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_cnt == c_timeout_last) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

    assign IN_READY   = w_in_ready;
    assign TX_DATA    = r_tx_data;
    assign TX_REQ_TGL = r_req_tgl;
    assign DONE       = r_done;

endmodule : cdc_handshake_tx
`default_nettype wire

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-domain half of the team's two-phase toggle handshake CDC link. It accepts a DATA_WIDTH-bit word on a valid/ready interface in the CLK domain and launches it as a held data bus plus a toggling request. It then waits for the destination's acknowledge toggle, brought back through an internal NUM_STAGES synchronizer, before accepting the next word. It is the transmitting counterpart of the destination-side handshake receiver in the synchronizers library.

## Interface
- DATA_WIDTH, 8: width of transferred word.
- NUM_STAGES, 2: flip-flop stages in ACK_TGL synchronizer; legal range 2..4.
- TIMEOUT_CYCLES, 255: cycles in WAIT_ACK before ERR; used only with CDC_TX_TIMEOUT_EN.

- CLK  input  1  source-domain clock.
- RST  input  1  reset, asynchronous, active-low.
- IN_VALID  input  1  source word valid.
- IN_DATA  input  DATA_WIDTH  source word.
- IN_READY  output  1  block can accept a word this cycle.
- TX_DATA  output  DATA_WIDTH  registered bus to destination, stable while a request is outstanding.
- TX_REQ_TGL  output  1  registered request toggle; each edge is one transfer.
- ACK_TGL  input  1  acknowledge toggle from destination domain; asynchronous to CLK.
- DONE  output  1  one-cycle pulse when an acknowledge is observed.
- ERR  output  1  sticky timeout flag; present only with CDC_TX_TIMEOUT_EN, otherwise tied 0.

## Operation
- Reset (RST low), all asynchronous:
  - State IDLE; TX_DATA = 0; TX_REQ_TGL = 0; DONE = 0; ERR = 0.
  - Synchronizer flops = 0; timeout counter = 0.
  - IN_READY = 0 while RST is low.
- States:
  - IDLE:
    - IN_READY = 1.
    - On IN_VALID && IN_READY: capture IN_DATA into TX_DATA, invert TX_REQ_TGL, clear timeout counter, go to WAIT_ACK.
  - WAIT_ACK:
    - IN_READY = 0; IN_VALID is ignored.
    - When ack_sync == TX_REQ_TGL: pulse DONE for one cycle, go to IDLE.
- ack_sync is ACK_TGL after NUM_STAGES flops. Completion is level equality, not edge detection, so back-to-back transfers need no extra state.
- TX_DATA and TX_REQ_TGL change only on acceptance. TX_DATA never changes while in WAIT_ACK, which is what makes the bus safe for the destination to sample.
- An ACK_TGL change while in IDLE (ack_sync already equals TX_REQ_TGL) has no effect.
- Reset mid-transfer:
  - The link returns to the all-zero state.
  - The destination must be reset in the same reset domain; a partial transfer is discarded.

## Timing
- Acceptance edge:
  - TX_DATA and TX_REQ_TGL update on the rising CLK edge where IN_VALID && IN_READY.
  - IN_READY drops to 0 the following cycle.
- The earliest DONE is NUM_STAGES cycles after the first CLK edge that samples the changed ACK_TGL.
- IN_READY returns to 1 in the cycle after DONE. DONE and IN_READY are never both high.
- Minimum accept-to-accept interval: 2 + NUM_STAGES + destination round trip.
- IN_READY is combinational from state (and RST). Everything else is registered.

## Configuration
- CDC_TX_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments each WAIT_ACK cycle and saturates.
  - On reaching TIMEOUT_CYCLES, ERR sets and stays 1 until reset.
  - The state remains WAIT_ACK, because the request cannot be retracted; a late ACK still completes normally with DONE.
- CDC_TX_TIMEOUT_EN undefined:
  - No counter is built and ERR is tied to 0.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Package cdc_pkg:
  - state enum (IDLE, WAIT_ACK).
  - Default constants for DATA_WIDTH, NUM_STAGES, TIMEOUT_CYCLES.
  - Legal NUM_STAGES bounds.
- Sub-module bit_sync:
  - Parameterised NUM_STAGES flop chain, async active-low reset to 0.
  - Instantiated for ACK_TGL; reusable by the receiver for its REQ toggle.

## Test plan
- Reset check: hold RST low with IN_VALID=1, IN_DATA=8'hA5 -> IN_READY=0, TX_DATA=0, TX_REQ_TGL=0. Release RST -> first accept captures 8'hA5 and TX_REQ_TGL=1.
- Single transfer: accept 8'h3C; a loopback model sets ACK_TGL=1 five cycles later -> DONE pulses exactly NUM_STAGES cycles after ACK is sampled, IN_READY=1 the next cycle, TX_DATA stays 8'h3C throughout WAIT_ACK.
- Back-to-back: three words 8'h01, 8'h02, 8'h03 with IN_VALID held high, ACK looped after NUM_STAGES cycles -> TX_REQ_TGL sequence 1, 0, 1; three DONE pulses; no word lost or duplicated.
- Spurious ACK: toggle ACK_TGL twice while in IDLE -> no DONE, no state change. Changing IN_DATA while in WAIT_ACK -> TX_DATA is unchanged.
- Mid-transfer reset: assert RST two cycles into WAIT_ACK -> all outputs return to reset values in the same cycle; the next transfer after release works normally.
- Timeout (CDC_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16): withhold ACK -> ERR=1 exactly 16 cycles after acceptance. A later ACK -> DONE pulses and ERR stays 1.
